// File: rtl/hdmi_timing_gen_pkg.sv
// Shared definitions for the HDMI timing generator: RGB565 layout, output
// word packing and the standard 640x480@60 raster constants.
package hdmi_timing_gen_pkg;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // Per-clock decode of the raster position; sync fields are "asserted"
  // flags, polarity is applied only at the output pins.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic origin;
  } raster_dec_t;

  // The output stage wants the green field split across the two bytes.
  function automatic logic [PIX_W-1:0] pack_565_swap(input rgb565_t px);
    return {px.g[2:0], px.b, px.r, px.g[5:3]};
  endfunction

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// Pixel-FIFO and video-output bundle between the timing generator (master)
// and its surroundings (slave).
interface hdmi_timing_gen_if;
  import hdmi_timing_gen_pkg::*;

  logic             enable;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_data;
  logic             fifo_rd;
  logic             uf_clear;
  logic             underflow;
  logic             frame_start;
  logic [PIX_W-1:0] p_dta;
  logic             en;
  logic             href;
  logic             vsync;

  modport master (
    input  enable, fifo_empty, fifo_data, uf_clear,
    output fifo_rd, underflow, frame_start, p_dta, en, href, vsync
  );

  modport slave (
    output enable, fifo_empty, fifo_data, uf_clear,
    input  fifo_rd, underflow, frame_start, p_dta, en, href, vsync
  );

endinterface

// File: rtl/hdmi_timing_gen_raster_counter.sv
// Horizontal/vertical raster counters with active-area and sync decode.
// Counters sit at the origin whenever i_run is low.
module hdmi_timing_gen_raster_counter
  import hdmi_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run,
  output raster_dec_t o_dec
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_wrap;
  logic          w_v_wrap;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // vsync decodes from v_cnt alone, so it changes exactly where h_cnt wraps.
  always_comb begin
    o_dec        = '0;
    o_dec.active = (r_h_cnt < H_ACT_E) && (r_v_cnt < V_ACT_E);
    o_dec.hs     = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    o_dec.vs     = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    o_dec.origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Video timing generator and FWFT pixel fetcher for the HDMI output stage:
// raster timing, RGB565 byte-swap repack, black substitution on underflow.
module hdmi_timing_gen
  import hdmi_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic               clk,
  input  logic               reset,
  hdmi_timing_gen_if.master  bus
);

  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  logic             r_run;
  logic             w_run;
  logic             w_act;
  logic             w_pop;
  logic             w_under;
  raster_dec_t      w_dec;

  logic             r_en_p1;
  logic             r_rd_p1;
  logic             r_fs_p1;
  logic             r_hs_p1;
  logic             r_vs_p1;
  logic [PIX_W-1:0] r_dta_p1;
  logic             r_uf;
  logic             r_hs_p2;
  logic             r_vs_p2;

  // r_run delays the first counted clock so a fresh enable always starts
  // the raster from a clean origin; dropping enable stops it at once.
  assign w_run   = bus.enable & r_run;
  assign w_act   = w_run & w_dec.active;
  assign w_pop   = w_act & ~bus.fifo_empty;
  assign w_under = w_act & bus.fifo_empty;

  hdmi_timing_gen_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .i_run (w_run),
    .o_dec (w_dec)
  );

  // Stage p1: pixel, enable, pop strobe and frame marker for the counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run    <= 1'b0;
      r_en_p1  <= 1'b0;
      r_rd_p1  <= 1'b0;
      r_fs_p1  <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
      r_dta_p1 <= '0;
      r_uf     <= 1'b0;
    end else begin
      r_run    <= bus.enable;
      r_en_p1  <= w_act;
      r_rd_p1  <= w_pop;
      r_fs_p1  <= w_run & w_dec.origin;
      r_hs_p1  <= w_run & w_dec.hs;
      r_vs_p1  <= w_run & w_dec.vs;
      r_dta_p1 <= w_pop ? pack_565_swap(rgb565_t'(bus.fifo_data)) : '0;
      if (w_under) begin
        r_uf <= 1'b1;
      end else if (bus.uf_clear) begin
        r_uf <= 1'b0;
      end
    end
  end

  // Stage p2: syncs lag one more clock because the downstream stage registers
  // pixel/enable but not syncs; a dropped enable still deasserts them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs_p2 <= 1'b0;
      r_vs_p2 <= 1'b0;
    end else begin
      r_hs_p2 <= bus.enable & r_hs_p1;
      r_vs_p2 <= bus.enable & r_vs_p1;
    end
  end

  assign bus.en          = r_en_p1;
  assign bus.fifo_rd     = r_rd_p1;
  assign bus.frame_start = r_fs_p1;
  assign bus.p_dta       = r_dta_p1;
  assign bus.underflow   = r_uf;
  assign bus.href        = r_hs_p2 ~^ HS_LVL;
  assign bus.vsync       = r_vs_p2 ~^ VS_LVL;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a small 15x8 raster: cycle scoreboard plus
// colour vectors and hand-written enable/underflow/reset sequences.
`timescale 1ns/1ps
module tb_hdmi_timing_gen;
  import hdmi_timing_gen_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hdmi_timing_gen_if bus();

  hdmi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        en, rd, fs, uf, hs, vs;
    logic [15:0] dta;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  int   m_h = 0, m_v = 0;
  logic m_run = 1'b0, m_uf = 1'b0;
  logic m_hs1 = 1'b0, m_vs1 = 1'b0, m_hs2 = 1'b0, m_vs2 = 1'b0;

  function automatic logic [15:0] bswap(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  // Reference raster: push the outputs each edge should produce.
  task automatic model_step();
    exp_t e;
    logic run, act;
    cyc++;
    if (!reset) begin
      m_run = 0; m_h = 0; m_v = 0; m_uf = 0;
      m_hs1 = 0; m_vs1 = 0; m_hs2 = 0; m_vs2 = 0;
      e.en = 0; e.rd = 0; e.fs = 0; e.uf = 0; e.hs = 1; e.vs = 1; e.dta = 16'h0000;
    end else begin
      run   = bus.enable && m_run;
      act   = run && (m_h < HA) && (m_v < VA);
      e.en  = act;
      e.rd  = act && !bus.fifo_empty;
      e.dta = e.rd ? bswap(bus.fifo_data) : 16'h0000;
      e.fs  = run && (m_h == 0) && (m_v == 0);
      if (act && bus.fifo_empty) m_uf = 1;
      else if (bus.uf_clear)     m_uf = 0;
      e.uf  = m_uf;
      m_hs2 = bus.enable && m_hs1;
      m_vs2 = bus.enable && m_vs1;
      m_hs1 = run && (m_h >= HA + HF) && (m_h < HA + HF + HS);
      m_vs1 = run && (m_v >= VA + VF) && (m_v < VA + VF + VS);
      e.hs  = !m_hs2;
      e.vs  = !m_vs2;
      if (!run) begin
        m_h = 0; m_v = 0;
      end else if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
      m_run = bus.enable;
    end
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (bus.en !== e.en || bus.fifo_rd !== e.rd || bus.frame_start !== e.fs ||
          bus.underflow !== e.uf || bus.href !== e.hs || bus.vsync !== e.vs ||
          bus.p_dta !== e.dta) begin
        errors++;
        $display("FAIL sb cyc=%0d got en=%b rd=%b fs=%b uf=%b href=%b vs=%b dta=%h exp en=%b rd=%b fs=%b uf=%b href=%b vs=%b dta=%h",
                 cyc, bus.en, bus.fifo_rd, bus.frame_start, bus.underflow, bus.href, bus.vsync, bus.p_dta,
                 e.en, e.rd, e.fs, e.uf, e.hs, e.vs, e.dta);
      end
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); sb_check(); end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ctl"}, {10'b0, bus.en, bus.fifo_rd, bus.frame_start, bus.underflow,
                         bus.href, bus.vsync}, 16'h0003);
    chk({name, "_dta"}, bus.p_dta, 16'h0000);
  endtask

  // Returns just after an edge, when the next edge will see state (h,v).
  task automatic wait_state(input int h, input int v);
    int n = 0;
    @(posedge clk); #1;
    while (!(m_h == h && m_v == v) && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_state h=%0d v=%0d got=timeout exp=reached", h, v);
    end
  endtask

  task automatic wait_active();
    int n = 0;
    @(posedge clk); #1;
    while (!(m_run && m_h < HA && m_v < VA) && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_active got=timeout exp=active");
    end
  endtask

  // Counts one frame of output starting at a frame_start negedge.
  task automatic frame_stats(input string name, input logic align);
    int   n_en = 0, n_hs = 0, n_vs = 0, n_fs = 0;
    int   k_en = -1, k_hs = -1, k_vs = -1;
    logic e_prev, ed_prev, en_d, fs_last;
    e_prev  = bus.en;
    ed_prev = 1'b0;
    fs_last = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      en_d = e_prev;
      if (en_d && !ed_prev && k_en < 0) k_en = k;
      ed_prev = en_d;
      e_prev  = bus.en;
      if (!bus.href  && k_hs < 0) k_hs = k;
      if (!bus.vsync && k_vs < 0) k_vs = k;
      n_en += int'(bus.en);
      n_hs += int'(!bus.href);
      n_vs += int'(!bus.vsync);
      n_fs += int'(bus.frame_start);
      fs_last = bus.frame_start;
    end
    chk({name, "_en_cnt"}, 16'(n_en), 16'd32);
    chk({name, "_fs_cnt"}, 16'(n_fs), 16'd1);
    chk({name, "_fs_period"}, {15'b0, fs_last}, 16'd1);
    if (align) begin
      chk({name, "_href_cnt"}, 16'(n_hs), 16'd24);
      chk({name, "_vsync_cnt"}, 16'(n_vs), 16'd30);
      chk({name, "_align_hs"}, 16'(k_hs - k_en), 16'(HA + HF));
      chk({name, "_align_vs"}, 16'(k_vs - k_en), 16'((VA + VF) * HT));
    end
  endtask

  initial begin
    vecs[0] = '{din: 16'hF800, exp: 16'h00F8};
    vecs[1] = '{din: 16'h07E0, exp: 16'hE007};
    vecs[2] = '{din: 16'h001F, exp: 16'h1F00};
    vecs[3] = '{din: 16'h1234, exp: 16'h3412};
    vecs[4] = '{din: 16'hFFFF, exp: 16'hFFFF};
    vecs[5] = '{din: 16'hA55A, exp: 16'h5AA5};

    bus.enable = 0; bus.fifo_empty = 0; bus.fifo_data = 16'h0000; bus.uf_clear = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 reset = 1;
    repeat (2) @(negedge clk);
    chk_reset_vals("idle");

    // Enable to first en: two clocks.
    @(posedge clk); #1 bus.enable = 1; bus.fifo_data = 16'hF800;
    @(posedge clk); @(negedge clk);
    chk("en_after_1", {15'b0, bus.en}, 16'd0);
    @(posedge clk); @(negedge clk);
    chk("en_after_2", {15'b0, bus.en}, 16'd1);
    chk("fs_first", {15'b0, bus.frame_start}, 16'd1);
    frame_stats("frame", 1'b1);

    for (int i = 0; i < 6; i++) begin
      wait_active();
      bus.fifo_data = vecs[i].din;
      @(posedge clk); @(negedge clk);
      chk($sformatf("color%0d", i), bus.p_dta, vecs[i].exp);
    end

    // Underflow on pixel 3 of line 0, then sticky, clear, and set-beats-clear.
    wait_state(3, 0);
    bus.fifo_empty = 1;
    @(posedge clk); #1 bus.fifo_empty = 0;
    @(negedge clk);
    chk("uf_dta", bus.p_dta, 16'h0000);
    chk("uf_rd", {15'b0, bus.fifo_rd}, 16'd0);
    chk("uf_set", {15'b0, bus.underflow}, 16'd1);
    repeat (5) @(negedge clk);
    chk("uf_hold", {15'b0, bus.underflow}, 16'd1);
    @(posedge clk); #1 bus.uf_clear = 1;
    @(posedge clk); #1 bus.uf_clear = 0;
    @(negedge clk);
    chk("uf_clear", {15'b0, bus.underflow}, 16'd0);
    wait_active();
    bus.fifo_empty = 1; bus.uf_clear = 1;
    @(posedge clk); #1 bus.fifo_empty = 0; bus.uf_clear = 0;
    @(negedge clk);
    chk("uf_set_wins", {15'b0, bus.underflow}, 16'd1);

    // Drop enable mid-line 2 while hsync is asserted.
    wait_state(12, 2);
    bus.enable = 0;
    @(posedge clk); @(negedge clk);
    chk("drop_en", {15'b0, bus.en}, 16'd0);
    chk("drop_rd", {15'b0, bus.fifo_rd}, 16'd0);
    chk("drop_syncs", {14'b0, bus.href, bus.vsync}, 16'd3);
    repeat (3) @(negedge clk);
    chk("drop_fs", {15'b0, bus.frame_start}, 16'd0);
    @(posedge clk); #1 bus.enable = 1;
    @(posedge clk); @(negedge clk);
    chk("reen_fs_1", {15'b0, bus.frame_start}, 16'd0);
    @(posedge clk); @(negedge clk);
    chk("reen_fs_2", {15'b0, bus.frame_start}, 16'd1);
    frame_stats("reen", 1'b0);

    // Asynchronous reset in the middle of active video.
    wait_state(5, 1);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_rd", {15'b0, bus.fifo_rd}, 16'd1);
    #1 reset = 0;
    #1 chk_reset_vals("async_rst");
    bus.enable = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst_rd", {15'b0, bus.fifo_rd}, 16'd0);
    end
    @(posedge clk); #1 reset = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_rd", {15'b0, bus.fifo_rd}, 16'd0);
    chk_reset_vals("post_rst");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
